ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test initiator for the 256x32 word RAM: it is the master side of the RAM's CLK/WR/Din/address/Dout interface.
- On a start pulse it runs a March C- sequence over every address, compares each read word against the expected background, and reports pass/fail with the first failing location.
- Sits between system control logic and the RAM. A system-level mux, outside this block, hands the RAM port to the BIST while busy is high.

Parameters:
- ADDR_W, 8: RAM address width; depth = 2^ADDR_W.
- DATA_W, 32: RAM word width.
- BG, 32'h00000000: background data. "0" writes BG; "1" writes ~BG.
- RD_LAT, 0: RAM read latency in cycles, 0 or 1. 0 means Dout is valid in the same cycle the address is presented.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to run the test.
- busy  out  1  high while the march sequence is executing.
- done  out  1  test finished; held until the next accepted start.
- fail  out  1  mismatch detected; valid when done=1.
- fail_elem  out  3  march element index (0..5) of the first mismatch.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_data  out  DATA_W  word actually read at the first mismatch.
- WR  out  1  RAM write enable.
- address  out  ADDR_W  RAM address.
- Din  out  DATA_W  RAM write data.
- Dout  in  DATA_W  RAM read data.

Behaviour:
- Reset: all outputs are 0 immediately, including WR (asynchronous). State is IDLE.
- States:
  - IDLE, DONE: waiting for start.
  - WRITE: one cycle, WR=1.
  - READ: WR=0.
  - RWAIT: present only when RD_LAT=1.
- start is accepted only in IDLE or DONE. On acceptance:
  - done, fail, fail_elem, fail_addr and fail_data clear.
  - busy rises on the next edge and the first op begins.
  - start while busy is ignored.
- March elements (up = address 0 to max, down = max to 0):
  - E0 up (w0)
  - E1 up (r0, w1)
  - E2 up (r1, w0)
  - E3 down (r0, w1)
  - E4 down (r1, w0)
  - E5 up (r0)
- Op timing:
  - Write: one cycle. WR=1, address and Din stable; the RAM captures the word at the rising edge ending the cycle.
  - Read: WR=0 for 1+RD_LAT cycles, address held. Din is driven with the expected value (don't care to the RAM).
  - Compare point: Dout is compared in the last read cycle (the same cycle if RD_LAT=0, the next cycle if RD_LAT=1).
- No idle cycles between ops, addresses or elements.
  - Address steps +1 or -1 after the last op at each address.
  - At the end of an element, address loads 0 (up) or 2^ADDR_W-1 (down) for the next element.
- Total busy cycles with no failure:
  - depth x (10 + 5 x RD_LAT).
  - ADDR_W=8: 2560 cycles (RD_LAT=0) or 3840 cycles (RD_LAT=1).
- Mismatch:
  - Checked on the full DATA_W width.
  - On the compare cycle, latch fail_elem, the current address into fail_addr, and Dout into fail_data; set fail=1.
  - Abort: the pending write is not issued.
  - Next cycle: busy=0, done=1, WR=0.
- Normal completion: on the cycle after E5's last read, busy=0, done=1, fail=0.
- WR is never 1 outside the WRITE state and never 1 in IDLE or DONE.
- Reset asserted mid-run: the test aborts with no further writes, and returns to IDLE with outputs as at reset.

Test Plan:
- Fault-free behavioural RAM, RD_LAT=0, start pulse → busy high for exactly 2560 cycles, then done=1, fail=0. WR pulse count = 256 x 5 = 1280.
- Same RAM, RD_LAT=1 → busy for exactly 3840 cycles, done=1, fail=0. Each read holds its address for 2 cycles.
- RAM model with bit 5 of address 8'h47 stuck at 1 → done=1, fail=1, fail_elem=1, fail_addr=8'h47, fail_data=32'h00000020. No WR after the compare cycle.
- Address-decoder fault (address bit 7 ignored, so 8'h80 aliases 8'h00) → fail=1, fail_elem=1, fail_addr=8'h80, fail_data=32'hFFFFFFFF.
- RST pulsed 100 cycles into a run → WR, busy and done go to 0 immediately. A later start gives a full 2560-cycle pass.
- start re-pulsed at cycles 10 and 500 of a run → ignored; completion is still at 2560 cycles. A start while done=1 clears done and fail and reruns the test.

Source files
------------

// File: rtl/ram_march_bist.sv
// March C- BIST master for a single-port word RAM.
// Drives WR/address/Din, checks Dout, and reports the first failing element, address and word.
module ram_march_bist #(
   parameter int                ADDR_W = 8,
   parameter int                DATA_W = 32,
   parameter logic [DATA_W-1:0] BG     = '0,
   parameter int                RD_LAT = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [2:0]        fail_elem,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic              WR,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] Din,
   input  logic [DATA_W-1:0] Dout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_RWAIT = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
   localparam logic [2:0]        ELEM_LAST = 3'd5;

   logic [2:0]        state_reg, state_next;
   logic [2:0]        elem_reg, elem_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic              fail_reg, fail_next;
   logic [2:0]        fail_elem_reg, fail_elem_next;
   logic [ADDR_W-1:0] fail_addr_reg, fail_addr_next;
   logic [DATA_W-1:0] fail_data_reg, fail_data_next;

   logic              elem_down;
   logic              addr_last;
   logic [ADDR_W-1:0] addr_step;
   logic [2:0]        elem_inc;
   logic [ADDR_W-1:0] elem_start;
   logic [DATA_W-1:0] exp_read;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] diff;
   logic              mismatch;
   logic              cmp;

   // Elements 3 and 4 walk downwards; 2 and 4 read the inverted background, 1 and 3 write it.
   assign elem_down  = (elem_reg == 3'd3) || (elem_reg == 3'd4);
   assign exp_read   = ((elem_reg == 3'd2) || (elem_reg == 3'd4)) ? ~BG : BG;
   assign wr_data    = ((elem_reg == 3'd1) || (elem_reg == 3'd3)) ? ~BG : BG;
   assign addr_last  = elem_down ? (addr_reg == '0) : (addr_reg == ADDR_MAX);
   assign addr_step  = elem_down ? (addr_reg - ADDR_W'(1)) : (addr_reg + ADDR_W'(1));
   assign elem_inc   = elem_reg + 3'd1;
   assign elem_start = ((elem_inc == 3'd3) || (elem_inc == 3'd4)) ? ADDR_MAX : '0;

   generate
      for (genvar gi = 0; gi < DATA_W; gi++) begin : g_diff
         assign diff[gi] = Dout[gi] ^ exp_read[gi];
      end
   endgenerate
   assign mismatch = |diff;

   // Dout is judged in the last cycle of a read.
   assign cmp = ((state_reg == S_READ) && (RD_LAT == 0)) || (state_reg == S_RWAIT);

   always_comb begin
      state_next     = state_reg;
      elem_next      = elem_reg;
      addr_next      = addr_reg;
      fail_next      = fail_reg;
      fail_elem_next = fail_elem_reg;
      fail_addr_next = fail_addr_reg;
      fail_data_next = fail_data_reg;
      case (state_reg)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_next     = S_WRITE;
               elem_next      = 3'd0;
               addr_next      = '0;
               fail_next      = 1'b0;
               fail_elem_next = 3'd0;
               fail_addr_next = '0;
               fail_data_next = '0;
            end
         end
         S_WRITE: begin
            if (addr_last) begin
               elem_next  = elem_inc;
               addr_next  = elem_start;
               state_next = S_READ;
            end else begin
               addr_next  = addr_step;
               state_next = (elem_reg == 3'd0) ? S_WRITE : S_READ;
            end
         end
         S_READ, S_RWAIT: begin
            if (!cmp) begin
               state_next = S_RWAIT;
            end else if (mismatch) begin
               fail_next      = 1'b1;
               fail_elem_next = elem_reg;
               fail_addr_next = addr_reg;
               fail_data_next = Dout;
               state_next     = S_DONE;
            end else if (elem_reg == ELEM_LAST) begin
               if (addr_last) begin
                  state_next = S_DONE;
               end else begin
                  addr_next  = addr_step;
                  state_next = S_READ;
               end
            end else begin
               state_next = S_WRITE;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= S_IDLE;
         elem_reg      <= 3'd0;
         addr_reg      <= '0;
         fail_reg      <= 1'b0;
         fail_elem_reg <= 3'd0;
         fail_addr_reg <= '0;
         fail_data_reg <= '0;
      end else begin
         state_reg     <= state_next;
         elem_reg      <= elem_next;
         addr_reg      <= addr_next;
         fail_reg      <= fail_next;
         fail_elem_reg <= fail_elem_next;
         fail_addr_reg <= fail_addr_next;
         fail_data_reg <= fail_data_next;
      end
   end

   assign busy      = (state_reg == S_WRITE) || (state_reg == S_READ) || (state_reg == S_RWAIT);
   assign done      = (state_reg == S_DONE);
   assign WR        = (state_reg == S_WRITE);
   assign address   = addr_reg;
   assign Din       = (state_reg == S_WRITE) ? wr_data :
                      (((state_reg == S_READ) || (state_reg == S_RWAIT)) ? exp_read : '0);
   assign fail      = fail_reg;
   assign fail_elem = fail_elem_reg;
   assign fail_addr = fail_addr_reg;
   assign fail_data = fail_data_reg;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: two instances (read latency 0 and 1) on behavioural RAMs with injectable faults.
module tb_ram_march_bist;

   typedef struct {
      logic        fail;
      logic [2:0]  elem;
      logic [7:0]  addr;
      logic [31:0] data;
      int          cycles;
      int          writes;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        start0 = 1'b0, start1 = 1'b0;
   logic        busy0, done0, fail0, wr0, busy1, done1, fail1, wr1;
   logic [2:0]  felem0, felem1;
   logic [7:0]  faddr0, faddr1, addr0, addr1;
   logic [31:0] fdata0, fdata1, din0, din1, dout0;
   logic [31:0] dout1 = '0;
   logic [31:0] mem0 [256];
   logic [31:0] mem1 [256];
   int          fault = 0;

   exp_t q0[$];
   exp_t q1[$];
   int   chk_cnt = 0, pass_cnt = 0, wr_outside = 0;

   always #5 CLK = ~CLK;

   ram_march_bist #(.ADDR_W(8), .DATA_W(32), .BG(32'h00000000), .RD_LAT(0)) dut0 (
      .CLK(CLK), .RST(RST), .start(start0), .busy(busy0), .done(done0), .fail(fail0),
      .fail_elem(felem0), .fail_addr(faddr0), .fail_data(fdata0),
      .WR(wr0), .address(addr0), .Din(din0), .Dout(dout0));

   ram_march_bist #(.ADDR_W(8), .DATA_W(32), .BG(32'h00000000), .RD_LAT(1)) dut1 (
      .CLK(CLK), .RST(RST), .start(start1), .busy(busy1), .done(done1), .fail(fail1),
      .fail_elem(felem1), .fail_addr(faddr1), .fail_data(fdata1),
      .WR(wr1), .address(addr1), .Din(din1), .Dout(dout1));

   // RAM 0: combinational read, optional stuck-at cell or address-bit-7 alias.
   always @(posedge CLK)
      if (wr0) mem0[(fault == 2) ? {1'b0, addr0[6:0]} : addr0] <= din0;

   always_comb begin
      dout0 = mem0[(fault == 2) ? {1'b0, addr0[6:0]} : addr0];
      if (fault == 1 && addr0 == 8'h47) dout0[5] = 1'b1;
   end

   // RAM 1: one-cycle registered read.
   always @(posedge CLK) begin
      if (wr1) mem1[addr1] <= din1;
      dout1 <= mem1[addr1];
   end

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endfunction

   function automatic exp_t mk(input logic f, input logic [2:0] e, input logic [7:0] a,
                               input logic [31:0] d, input int c, input int w);
      exp_t x;
      x.fail = f; x.elem = e; x.addr = a; x.data = d; x.cycles = c; x.writes = w;
      return x;
   endfunction

   // Monitor for instance 0.
   initial begin
      int   bc = 0, wc = 0;
      logic done_q = 1'b0;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST) begin
            bc = 0; wc = 0; done_q = 1'b0;
         end else begin
            if (busy0) bc++;
            if (wr0) wc++;
            if (wr0 && !busy0) wr_outside++;
            if (done0 && !done_q) begin
               if (q0.size() == 0) begin
                  chk("dut0_unexpected_done", 64'd1, 64'd0);
               end else begin
                  e = q0.pop_front();
                  $display("dut0 run: fail=%0d elem=%0d addr=%02h data=%08h busy=%0d writes=%0d",
                           fail0, felem0, faddr0, fdata0, bc, wc);
                  chk("dut0_fail", 64'(fail0), 64'(e.fail));
                  chk("dut0_busy_cycles", 64'(bc), 64'(e.cycles));
                  chk("dut0_writes", 64'(wc), 64'(e.writes));
                  if (e.fail) begin
                     chk("dut0_fail_elem", 64'(felem0), 64'(e.elem));
                     chk("dut0_fail_addr", 64'(faddr0), 64'(e.addr));
                     chk("dut0_fail_data", 64'(fdata0), 64'(e.data));
                  end
               end
               bc = 0; wc = 0;
            end
            done_q = done0;
         end
      end
   end

   // Monitor for instance 1.
   initial begin
      int   bc = 0, wc = 0;
      logic done_q = 1'b0;
      exp_t e;
      forever begin
         @(negedge CLK);
         if (RST) begin
            bc = 0; wc = 0; done_q = 1'b0;
         end else begin
            if (busy1) bc++;
            if (wr1) wc++;
            if (wr1 && !busy1) wr_outside++;
            if (done1 && !done_q) begin
               if (q1.size() == 0) begin
                  chk("dut1_unexpected_done", 64'd1, 64'd0);
               end else begin
                  e = q1.pop_front();
                  $display("dut1 run: fail=%0d elem=%0d addr=%02h data=%08h busy=%0d writes=%0d",
                           fail1, felem1, faddr1, fdata1, bc, wc);
                  chk("dut1_fail", 64'(fail1), 64'(e.fail));
                  chk("dut1_busy_cycles", 64'(bc), 64'(e.cycles));
                  chk("dut1_writes", 64'(wc), 64'(e.writes));
               end
               bc = 0; wc = 0;
            end
            done_q = done1;
         end
      end
   end

   task automatic pulse0();
      @(negedge CLK);
      start0 = 1'b1;
      @(posedge CLK);
      #1 start0 = 1'b0;
   endtask

   task automatic pulse1();
      @(negedge CLK);
      start1 = 1'b1;
      @(posedge CLK);
      #1 start1 = 1'b0;
   endtask

   task automatic wait_done0(input int limit);
      int n = 0;
      while (!done0 && n < limit) begin
         @(negedge CLK);
         n++;
      end
      chk("dut0_done_reached", 64'(done0), 64'd1);
      repeat (2) @(negedge CLK);
   endtask

   task automatic wait_done1(input int limit);
      int n = 0;
      while (!done1 && n < limit) begin
         @(negedge CLK);
         n++;
      end
      chk("dut1_done_reached", 64'(done1), 64'd1);
      repeat (2) @(negedge CLK);
   endtask

   initial begin
      #2;
      chk("reset_busy", 64'(busy0), 64'd0);
      chk("reset_done", 64'(done0), 64'd0);
      chk("reset_wr", 64'(wr0), 64'd0);
      chk("reset_din", 64'(din0), 64'd0);
      chk("reset_fail", 64'(fail0), 64'd0);
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      // Fault-free, latency 0.
      q0.push_back(mk(1'b0, 3'd0, 8'h00, 32'h0, 2560, 1280));
      pulse0();
      wait_done0(3000);

      // Fault-free, latency 1.
      q1.push_back(mk(1'b0, 3'd0, 8'h00, 32'h0, 3840, 1280));
      pulse1();
      wait_done1(4500);

      // Bit 5 of address 0x47 stuck at 1.
      fault = 1;
      q0.push_back(mk(1'b1, 3'd1, 8'h47, 32'h00000020, 399, 327));
      pulse0();
      wait_done0(3000);

      // Start while done: outputs clear and a clean rerun passes.
      fault = 0;
      q0.push_back(mk(1'b0, 3'd0, 8'h00, 32'h0, 2560, 1280));
      pulse0();
      chk("restart_done_clear", 64'(done0), 64'd0);
      chk("restart_fail_clear", 64'(fail0), 64'd0);
      chk("restart_busy", 64'(busy0), 64'd1);
      wait_done0(3000);

      // Address bit 7 ignored: 0x80 aliases 0x00.
      fault = 2;
      q0.push_back(mk(1'b1, 3'd1, 8'h80, 32'hFFFFFFFF, 513, 384));
      pulse0();
      wait_done0(3000);

      // Reset 100 cycles into a run.
      fault = 0;
      pulse0();
      repeat (100) @(negedge CLK);
      chk("pre_rst_wr", 64'(wr0), 64'd1);
      #2 RST = 1'b1;
      #1;
      chk("rst_wr", 64'(wr0), 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_done", 64'(done0), 64'd0);
      chk("rst_addr", 64'(addr0), 64'd0);
      @(negedge CLK);
      RST = 1'b0;
      q0.push_back(mk(1'b0, 3'd0, 8'h00, 32'h0, 2560, 1280));
      pulse0();
      wait_done0(3000);

      // Start re-pulsed while busy is ignored.
      q0.push_back(mk(1'b0, 3'd0, 8'h00, 32'h0, 2560, 1280));
      pulse0();
      repeat (8) @(negedge CLK);
      pulse0();
      repeat (488) @(negedge CLK);
      pulse0();
      wait_done0(3000);

      chk("wr_outside_busy", 64'(wr_outside), 64'd0);
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
